// File: rtl/bmp_stream_loader_if.sv
// -----------------------------------------------------------------------------
// bmp_stream_loader_if
//
// Purpose:
//   Bundles the start handshake, the ROM read port, the RAM write port and the
//   completion flag of the BMP ROM->RAM loader.
//
// Modports:
//   master : the loader itself (drives ROM/RAM control, load_done)
//   slave  : the environment (drives in_valid, mode, ROM_out)
//
// Signals:
//   in_valid  start request (level)
//   mode      pixel mode: 0 copy, 1 invert, 2 threshold, 3 copy
//   ROM_out   ROM read data, valid one cycle after ROM_ren
//   ROM_ren   ROM read enable
//   ROM_addr  ROM read address
//   RAM_ren   RAM read enable (tied low)
//   RAM_wen   RAM write enable
//   RAM_in    RAM write data
//   RAM_addr  RAM write address
//   load_done image fully written
//   checksum  16-bit sum of written bytes (only with BMP_CHECKSUM_EN)
//
// Optional feature macro: BMP_CHECKSUM_EN
// -----------------------------------------------------------------------------
interface bmp_stream_loader_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20
);
  logic                  in_valid;
  logic [1:0]            mode;
  logic [BYTE_WIDTH-1:0] ROM_out;
  logic                  ROM_ren;
  logic [ADDR_WIDTH-1:0] ROM_addr;
  logic                  RAM_ren;
  logic                  RAM_wen;
  logic [BYTE_WIDTH-1:0] RAM_in;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic                  load_done;
`ifdef BMP_CHECKSUM_EN
  logic [15:0]           checksum;

  modport master (
    input  in_valid, mode, ROM_out,
    output ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr, load_done,
           checksum
  );

  modport slave (
    output in_valid, mode, ROM_out,
    input  ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr, load_done,
           checksum
  );
`else
  modport master (
    input  in_valid, mode, ROM_out,
    output ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr, load_done
  );

  modport slave (
    output in_valid, mode, ROM_out,
    input  ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr, load_done
  );
`endif
endinterface

// File: rtl/bmp_stream_loader.sv
// -----------------------------------------------------------------------------
// bmp_stream_loader
//
// Purpose:
//   Streams TOTAL_SIZE bytes from a BMP ROM into a single-port RAM, one byte
//   per cycle. The first HEADER_SIZE bytes (file header) are copied verbatim;
//   pixel bytes pass through a per-run function selected by mode:
//     0 / 3 : copy
//     1     : bitwise invert
//     2     : threshold (all-ones if byte >= THRESH, else zero)
//   The mode is captured on the start edge and held for the whole run.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bmp_stream_loader_if.master (handshake, ROM read, RAM write, done)
//
// Timing:
//   Start edge -> READ issues addresses 0..TOTAL_SIZE-1 on consecutive cycles.
//   ROM data returns one cycle later and is written to RAM the same cycle
//   (RAM_in is combinational from ROM_out while RAM_wen is high). One DRAIN
//   cycle carries the final write, then DONE holds load_done until in_valid
//   drops.
//
// Optional feature macro: BMP_CHECKSUM_EN
//   Adds bus.checksum: sum mod 2**16 of every byte written this run.
// -----------------------------------------------------------------------------
module bmp_stream_loader #(
  parameter int BYTE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 20,
  parameter int TOTAL_SIZE  = 786486,
  parameter int HEADER_SIZE = 54,
  parameter int THRESH      = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bmp_stream_loader_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_COPY   = 2'd0,
    M_INVERT = 2'd1,
    M_THRESH = 2'd2,
    M_RSVD   = 2'd3
  } mode_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] HDR_END   = ADDR_WIDTH'(HEADER_SIZE);
  localparam logic [BYTE_WIDTH-1:0] THRESH_V  = BYTE_WIDTH'(THRESH);

  state_t                state_q;
  state_t                state_nxt;
  mode_t                 mode_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q;
  logic                  wr_valid_q;   // a ROM read was issued last cycle
  logic [ADDR_WIDTH-1:0] wr_addr_q;    // address of that read
  logic [BYTE_WIDTH-1:0] last_in_q;    // last written byte, shown when idle
  logic [BYTE_WIDTH-1:0] pix_out;
  logic [BYTE_WIDTH-1:0] ram_in;
  logic                  start;
  logic                  rom_ren;
  logic                  load_done;

  assign start = (state_q == S_IDLE) && bus.in_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid)         state_nxt = S_READ;
      S_READ:  if (rd_cnt_q == LAST_ADDR) state_nxt = S_DRAIN;
      S_DRAIN:                           state_nxt = S_DONE;
      S_DONE:  if (!bus.in_valid)        state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rom_ren   = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      S_READ:  rom_ren   = 1'b1;
      S_DONE:  load_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read counter, latched mode, write pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q   <= '0;
      mode_q     <= M_COPY;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      last_in_q  <= '0;
    end else begin
      if (start) begin
        rd_cnt_q <= '0;
        mode_q   <= mode_t'(bus.mode);
      end else if (state_q == S_READ && rd_cnt_q != LAST_ADDR) begin
        // Saturates at LAST_ADDR so no address past the image is ever issued.
        rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
      end

      wr_valid_q <= (state_q == S_READ);
      if (state_q == S_READ) wr_addr_q <= rd_cnt_q;
      if (wr_valid_q)        last_in_q <= pix_out;
    end
  end

  // Pixel function; header bytes always bypass it.
  always_comb begin
    pix_out = bus.ROM_out;
    if (wr_addr_q >= HDR_END) begin
      unique case (mode_q)
        M_INVERT: pix_out = ~bus.ROM_out;
        M_THRESH: pix_out = (bus.ROM_out >= THRESH_V) ? '1 : '0;
        default:  pix_out = bus.ROM_out;
      endcase
    end
  end

  // Live data during a write, otherwise hold the last written byte.
  assign ram_in = wr_valid_q ? pix_out : last_in_q;

`ifdef BMP_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running checksum of written bytes
  // ---------------------------------------------------------------------------
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum_q <= '0;
    else if (start)      csum_q <= '0;
    else if (wr_valid_q) csum_q <= csum_q + 16'(ram_in);
  end

  assign bus.checksum = csum_q;
`endif

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.ROM_ren   = rom_ren;
  assign bus.ROM_addr  = rd_cnt_q;
  assign bus.RAM_ren   = 1'b0;
  assign bus.RAM_wen   = wr_valid_q;
  assign bus.RAM_in    = ram_in;
  assign bus.RAM_addr  = wr_addr_q;
  assign bus.load_done = load_done;

endmodule
